// File: rtl/vip_cfg_responder_if.sv
// rtl/vip_cfg_responder_if.sv - Avalon-MM configuration bus bundle for vip_cfg_responder
// Ports: address/write/writedata/read driven by the master; readdata/readdatavalid/
// waitrequest driven by the slave.
interface vip_cfg_responder_if;
    logic [8:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/vip_cfg_responder.sv
// rtl/vip_cfg_responder.sv - VIP configuration register responder with frame-synchronous commit
// Ports: clk, reset_n (async active-low); bus (Avalon-MM slave); frame_start (frame boundary
// pulse); scl_*/mix_*/vm_* active geometry; run (per-unit running); commit (per-unit update pulse).
module vip_cfg_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DW          = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    vip_cfg_responder_if.slave bus,
    input  logic               frame_start,
    output logic [DW-1:0]      scl_w,
    output logic [DW-1:0]      scl_h,
    output logic [DW-1:0]      mix_bw,
    output logic [DW-1:0]      mix_bh,
    output logic [DW-1:0]      mix_px,
    output logic [DW-1:0]      mix_py,
    output logic               mix_en,
    output logic [DW-1:0]      vm_w,
    output logic [DW-1:0]      vm_h,
    output logic [DW-1:0]      vm_hfp,
    output logic [DW-1:0]      vm_hs,
    output logic [DW-1:0]      vm_hbl,
    output logic [DW-1:0]      vm_vfp,
    output logic [DW-1:0]      vm_vs,
    output logic [DW-1:0]      vm_vbl,
    output logic               vm_intl,
    output logic [2:0]         run,
    output logic [2:0]         commit
);
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

    logic [7:0]    wcnt_q, wcnt_d;
    logic          wait_q, rdv_q;
    logic [31:0]   rdata_q, rd_val;
    logic [2:0]    run_q, pend_q, commit_q, go_wr, do_commit;

    // Shadow (bus-visible) and active (driven) register sets.
    logic [DW-1:0] sh_scl_q [2];
    logic [DW-1:0] ac_scl_q [2];
    logic [DW-1:0] sh_mix_q [4];   // bw, bh, px, py
    logic [DW-1:0] ac_mix_q [4];
    logic [DW-1:0] sh_vm_q  [8];   // w, h, hfp, hs, hbl, vfp, vs, vbl
    logic [DW-1:0] ac_vm_q  [8];
    logic [DW-1:0] sh_bank_q;
    logic          sh_en_q, ac_en_q, sh_intl_q, ac_intl_q, sh_valid_q;

    logic          wr_acc, rd_acc;
    logic          scl_hit, mix_hit, vm_hit;
    logic          scl_sel;
    logic [1:0]    mix_sel;
    logic [2:0]    vm_sel;

    assign wr_acc = bus.write && !wait_q;
    assign rd_acc = bus.read && !wait_q;

    assign go_wr[0] = wr_acc && (bus.address == 9'h000);
    assign go_wr[1] = wr_acc && (bus.address == 9'h080);
    assign go_wr[2] = wr_acc && (bus.address == 9'h100);

    // A same-cycle Go=0 cancels the pending commit so active values really are kept.
    // Video mode additionally waits for its shadow valid bit.
    always_comb begin
        do_commit = '0;
        for (int u = 0; u < 3; u++) begin
            do_commit[u] = frame_start && pend_q[u] && !(go_wr[u] && !bus.writedata[0]);
        end
        do_commit[2] = do_commit[2] && sh_valid_q;
    end

    always_comb begin
        scl_hit = 1'b0; scl_sel = 1'b0;
        mix_hit = 1'b0; mix_sel = 2'd0;
        vm_hit  = 1'b0; vm_sel  = 3'd0;
        case (bus.address)
            9'h003: begin scl_hit = 1'b1; scl_sel = 1'b0; end
            9'h004: begin scl_hit = 1'b1; scl_sel = 1'b1; end
            9'h083: begin mix_hit = 1'b1; mix_sel = 2'd0; end
            9'h084: begin mix_hit = 1'b1; mix_sel = 2'd1; end
            9'h088: begin mix_hit = 1'b1; mix_sel = 2'd2; end
            9'h089: begin mix_hit = 1'b1; mix_sel = 2'd3; end
            9'h106: begin vm_hit  = 1'b1; vm_sel  = 3'd0; end
            9'h107: begin vm_hit  = 1'b1; vm_sel  = 3'd1; end
            9'h109: begin vm_hit  = 1'b1; vm_sel  = 3'd2; end
            9'h10A: begin vm_hit  = 1'b1; vm_sel  = 3'd3; end
            9'h10B: begin vm_hit  = 1'b1; vm_sel  = 3'd4; end
            9'h10C: begin vm_hit  = 1'b1; vm_sel  = 3'd5; end
            9'h10D: begin vm_hit  = 1'b1; vm_sel  = 3'd6; end
            9'h10E: begin vm_hit  = 1'b1; vm_sel  = 3'd7; end
            default: ;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (scl_hit) rd_val = 32'(sh_scl_q[scl_sel]);
        if (mix_hit) rd_val = 32'(sh_mix_q[mix_sel]);
        if (vm_hit)  rd_val = 32'(sh_vm_q[vm_sel]);
        case (bus.address)
            9'h000: rd_val = {30'b0, pend_q[0], run_q[0]};
            9'h080: rd_val = {30'b0, pend_q[1], run_q[1]};
            9'h100: rd_val = {30'b0, pend_q[2], run_q[2]};
            9'h08A: rd_val = 32'(sh_en_q);
            9'h104: rd_val = 32'(sh_bank_q);
            9'h105: rd_val = 32'(sh_intl_q);
            9'h11E: rd_val = 32'(sh_valid_q);
            default: ;
        endcase
    end

    always_comb begin
        if (wr_acc)              wcnt_d = WAIT_LD;
        else if (wcnt_q != 8'd0) wcnt_d = wcnt_q - 8'd1;
        else                     wcnt_d = wcnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q     <= '0;
            wait_q     <= 1'b0;
            rdv_q      <= 1'b0;
            rdata_q    <= '0;
            run_q      <= '0;
            pend_q     <= '0;
            commit_q   <= '0;
            sh_bank_q  <= '0;
            sh_en_q    <= 1'b0;
            ac_en_q    <= 1'b0;
            sh_intl_q  <= 1'b0;
            ac_intl_q  <= 1'b0;
            sh_valid_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin sh_scl_q[i] <= '0; ac_scl_q[i] <= '0; end
            for (int i = 0; i < 4; i++) begin sh_mix_q[i] <= '0; ac_mix_q[i] <= '0; end
            for (int i = 0; i < 8; i++) begin sh_vm_q[i]  <= '0; ac_vm_q[i]  <= '0; end
        end else begin
            wcnt_q   <= wcnt_d;
            wait_q   <= (wcnt_d != 8'd0);
            rdv_q    <= rd_acc;
            commit_q <= do_commit;
            // Read samples pre-write shadow, so a simultaneous write is not visible.
            if (rd_acc) rdata_q <= rd_val;

            // Commits copy the pre-edge shadow; a coinciding shadow write lands after.
            if (do_commit[0]) for (int i = 0; i < 2; i++) ac_scl_q[i] <= sh_scl_q[i];
            if (do_commit[1]) begin
                for (int i = 0; i < 4; i++) ac_mix_q[i] <= sh_mix_q[i];
                ac_en_q <= sh_en_q;
            end
            if (do_commit[2]) begin
                for (int i = 0; i < 8; i++) ac_vm_q[i] <= sh_vm_q[i];
                ac_intl_q <= sh_intl_q;
            end

            // Go write after the commit clear, so a coinciding Go=1 leaves pend set.
            for (int u = 0; u < 3; u++) begin
                if (do_commit[u]) pend_q[u] <= 1'b0;
                if (go_wr[u]) begin
                    run_q[u]  <= bus.writedata[0];
                    pend_q[u] <= bus.writedata[0];
                end
            end

            if (wr_acc) begin
                if (scl_hit) sh_scl_q[scl_sel] <= bus.writedata[DW-1:0];
                if (mix_hit) sh_mix_q[mix_sel] <= bus.writedata[DW-1:0];
                if (vm_hit)  sh_vm_q[vm_sel]   <= bus.writedata[DW-1:0];
                case (bus.address)
                    9'h08A: sh_en_q    <= bus.writedata[0];
                    9'h104: sh_bank_q  <= bus.writedata[DW-1:0];
                    9'h105: sh_intl_q  <= bus.writedata[0];
                    9'h11E: sh_valid_q <= bus.writedata[0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.waitrequest   = wait_q;
    assign bus.readdatavalid = rdv_q;
    assign bus.readdata      = rdata_q;

    assign scl_w   = ac_scl_q[0];
    assign scl_h   = ac_scl_q[1];
    assign mix_bw  = ac_mix_q[0];
    assign mix_bh  = ac_mix_q[1];
    assign mix_px  = ac_mix_q[2];
    assign mix_py  = ac_mix_q[3];
    assign mix_en  = ac_en_q && run_q[1];
    assign vm_w    = ac_vm_q[0];
    assign vm_h    = ac_vm_q[1];
    assign vm_hfp  = ac_vm_q[2];
    assign vm_hs   = ac_vm_q[3];
    assign vm_hbl  = ac_vm_q[4];
    assign vm_vfp  = ac_vm_q[5];
    assign vm_vs   = ac_vm_q[6];
    assign vm_vbl  = ac_vm_q[7];
    assign vm_intl = ac_intl_q;
    assign run     = run_q;
    assign commit  = commit_q;
endmodule
